// File: rtl/poci_pkg.sv
// Shared types and constants for the Poci (APB) timer responder.
package poci_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } poci_state_e;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_LOAD     = 8'h04;
    localparam logic [7:0] OFF_VALUE    = 8'h08;
    localparam logic [7:0] OFF_STATUS   = 8'h0C;
    localparam logic [7:0] OFF_PRESCALE = 8'h10;

    localparam int unsigned CTRL_EN        = 0;
    localparam int unsigned CTRL_RELOAD    = 1;
    localparam int unsigned CTRL_IRQEN     = 2;
    localparam int unsigned STATUS_EXPIRED = 0;

endpackage

// File: rtl/poci_slave_if.sv
// APB responder handshake: IDLE/SETUP/ACCESS sequencing with a programmable wait-state count.
module poci_slave_if
    import poci_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] i_paddr,
    input  logic       i_pwrite,
    input  logic       i_psel,
    input  logic       i_penable,
    output logic       o_pready,
    output logic       o_wr_stb,
    output logic       o_rd_stb,
    output logic [7:0] o_offset,
    output logic       o_misaligned
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    poci_state_e r_state;
    poci_state_e w_state_nxt;
    logic [3:0]  r_wcnt;
    logic        w_done;

    // Dropping psel mid-transfer must suppress completion, so done is gated by psel.
    assign w_done = (r_state == ACCESS) && i_psel && (r_wcnt == WS);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (i_psel && !i_penable) w_state_nxt = SETUP;
            end
            SETUP: begin
                if (!i_psel)        w_state_nxt = IDLE;
                else if (i_penable) w_state_nxt = ACCESS;
            end
            ACCESS: begin
                if (!i_psel || w_done) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == SETUP && i_psel && i_penable)
                r_wcnt <= '0;
            else if (r_state == ACCESS && !w_done && r_wcnt != '1)
                r_wcnt <= r_wcnt + 4'd1;
        end
    end

    assign o_pready     = w_done;
    assign o_wr_stb     = w_done && i_pwrite;
    assign o_rd_stb     = w_done && !i_pwrite;
    assign o_offset     = i_paddr;
    assign o_misaligned = |i_paddr[1:0];

endmodule

// File: rtl/poci_timer.sv
// APB down-counting timer with interrupt. Optional prescaler (0x10) enabled by
// defining POCI_TIMER_PRESCALE_EN; otherwise the timer ticks every cycle.
module poci_timer
    import poci_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] RESET_LOAD  = '0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] io_in_paddr,
    input  logic        io_in_pwrite,
    input  logic        io_in_psel,
    input  logic        io_in_penable,
    input  logic [31:0] io_in_pwdata,
    output logic [31:0] io_in_prdata,
    output logic        io_in_pready,
    output logic        io_in_pslverr,
    output logic        io_irq
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             w_pready, w_wr_stb, w_rd_stb, w_misaligned;
    logic [7:0]       w_offset;
    logic             w_hit, w_err, w_wr_ok, w_tick;
    logic             w_wr_ctrl, w_wr_load, w_wr_status;
    logic [31:0]      w_rdata;
    logic             w_unused_bits;

    logic [2:0]       r_ctrl;
    logic [WIDTH-1:0] r_load;
    logic [WIDTH-1:0] r_value;
    logic             r_expired;
    logic             r_irq;

    poci_slave_if #(.WAIT_STATES(WAIT_STATES)) u_if (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_paddr      (io_in_paddr[7:0]),
        .i_pwrite     (io_in_pwrite),
        .i_psel       (io_in_psel),
        .i_penable    (io_in_penable),
        .o_pready     (w_pready),
        .o_wr_stb     (w_wr_stb),
        .o_rd_stb     (w_rd_stb),
        .o_offset     (w_offset),
        .o_misaligned (w_misaligned)
    );

    assign w_unused_bits = ^{io_in_paddr[31:8], io_in_pwdata};

`ifdef POCI_TIMER_PRESCALE_EN
    logic [7:0] r_prescale;
    logic [7:0] r_pcnt;
    logic       w_wr_pre;
`endif

    always_comb begin
        w_hit   = 1'b1;
        w_rdata = '0;
        case (w_offset)
            OFF_CTRL:     w_rdata = 32'(r_ctrl);
            OFF_LOAD:     w_rdata = 32'(r_load);
            OFF_VALUE:    w_rdata = 32'(r_value);
            OFF_STATUS:   w_rdata = 32'(r_expired);
`ifdef POCI_TIMER_PRESCALE_EN
            OFF_PRESCALE: w_rdata = 32'(r_prescale);
`endif
            default:      w_hit = 1'b0;
        endcase
    end

    assign w_err       = w_misaligned || !w_hit || (io_in_pwrite && w_offset == OFF_VALUE);
    assign w_wr_ok     = w_wr_stb && !w_err;
    assign w_wr_ctrl   = w_wr_ok && (w_offset == OFF_CTRL);
    assign w_wr_load   = w_wr_ok && (w_offset == OFF_LOAD);
    assign w_wr_status = w_wr_ok && (w_offset == OFF_STATUS);

    assign io_in_pready  = w_pready;
    assign io_in_pslverr = w_pready && w_err;
    assign io_in_prdata  = (w_rd_stb && !w_err) ? w_rdata : '0;
    assign io_irq        = r_irq;

`ifdef POCI_TIMER_PRESCALE_EN
    assign w_wr_pre = w_wr_ok && (w_offset == OFF_PRESCALE);
    assign w_tick   = r_ctrl[CTRL_EN] && (r_pcnt == r_prescale);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prescale <= '0;
            r_pcnt     <= '0;
        end else begin
            if (w_wr_pre) r_prescale <= io_in_pwdata[7:0];
            if (w_wr_ctrl || !r_ctrl[CTRL_EN] || r_pcnt == r_prescale)
                r_pcnt <= '0;
            else
                r_pcnt <= r_pcnt + 8'd1;
        end
    end
`else
    assign w_tick = r_ctrl[CTRL_EN];
`endif

    // Statement order encodes priority: expiry set beats W1C, bus writes beat the counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl    <= '0;
            r_load    <= RESET_LOAD[WIDTH-1:0];
            r_value   <= RESET_LOAD[WIDTH-1:0];
            r_expired <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_irq <= r_expired && r_ctrl[CTRL_IRQEN];
            if (w_wr_status && io_in_pwdata[STATUS_EXPIRED])
                r_expired <= 1'b0;
            if (w_tick) begin
                if (r_value != '0) begin
                    r_value <= r_value - ONE;
                end else begin
                    r_expired <= 1'b1;
                    if (r_ctrl[CTRL_RELOAD]) r_value <= r_load;
                    else                     r_ctrl[CTRL_EN] <= 1'b0;
                end
            end
            if (w_wr_ctrl) r_ctrl <= io_in_pwdata[2:0];
            if (w_wr_load) begin
                r_load  <= io_in_pwdata[WIDTH-1:0];
                r_value <= io_in_pwdata[WIDTH-1:0];
            end
        end
    end

endmodule
